// File: rtl/pds_operand_sequencer_if.sv
// Operand/result bundle between the sequencer, its upstream word source,
// the PDT_SUM_DIFF datapath and the result consumer.
interface pds_operand_sequencer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] o_in;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic [7:0]  op_count;

    // Environment side: feeds words, supplies the datapath result, consumes results
    modport master (
        output in_data, in_valid, o_in, res_ready,
        input  in_ready, x, y, res_data, res_valid, busy, op_count
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, o_in, res_ready,
        output in_ready, x, y, res_data, res_valid, busy, op_count
    );
endinterface

// File: rtl/pds_operand_sequencer.sv
// Upstream controller for PDT_SUM_DIFF: pairs stream words into X/Y, holds
// them while the datapath settles for LATENCY edges, captures the result
// verbatim and offers it on a valid/ready port. One operation in flight.
module pds_operand_sequencer #(
    parameter int unsigned LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pds_operand_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_X    = 2'd0,
        S_Y    = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Settle counter starts at LATENCY-1 so capture lands LATENCY edges after Y accept
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [31:0] res_data_r;
    logic        res_valid_r;
    logic [7:0]  op_count_r;

    // Ready and busy are pure decodes of the state register, so reset forces ready high
    assign bus.in_ready  = (state == S_X) || (state == S_Y);
    assign bus.busy      = (state != S_X);
    assign bus.x         = x_r;
    assign bus.y         = y_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_valid = res_valid_r;
    assign bus.op_count  = op_count_r;

    // Sequencer FSM with all operand, result and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_X;
            cnt         <= 4'd0;
            x_r         <= 16'd0;
            y_r         <= 16'd0;
            res_data_r  <= 32'd0;
            res_valid_r <= 1'b0;
            op_count_r  <= 8'd0;
        end else begin
            case (state)
                S_X: begin
                    if (bus.in_valid) begin
                        x_r   <= bus.in_data;
                        state <= S_Y;
                    end
                end
                S_Y: begin
                    if (bus.in_valid) begin
                        y_r   <= bus.in_data;
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        res_data_r  <= bus.o_in;
                        res_valid_r <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + 8'd1;
                        state       <= S_X;
                    end
                end
                default: begin
                    state <= S_X;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pds_operand_sequencer.sv
// Scoreboard bench for pds_operand_sequencer: a LATENCY=4 and a LATENCY=1
// instance share one stimulus port through a select, each with a model of
// PDT_SUM_DIFF driving its O_IN.
module tb_pds_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] x;
        logic [15:0] y;
        time         yt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_x = 16'd0;
    logic [7:0]  exp_ops_a = 8'd0;
    logic [7:0]  exp_ops_b = 8'd0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    pds_operand_sequencer_if ifa();
    pds_operand_sequencer_if ifb();

    // Reference for the external datapath: 16-bit wrapping sum/diff, 32-bit product
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [15:0] d;
        s = a + b;
        d = a - b;
        return {16'd0, s} * {16'd0, d};
    endfunction

    assign ifa.in_data   = in_data;
    assign ifa.in_valid  = in_valid & ~sel;
    assign ifa.res_ready = res_ready & ~sel;
    assign ifa.o_in      = model(ifa.x, ifa.y);
    assign ifb.in_data   = in_data;
    assign ifb.in_valid  = in_valid & sel;
    assign ifb.res_ready = res_ready & sel;
    assign ifb.o_in      = model(ifb.x, ifb.y);

    wire        m_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
    wire        m_busy      = sel ? ifb.busy      : ifa.busy;
    wire [15:0] m_x         = sel ? ifb.x         : ifa.x;
    wire [15:0] m_y         = sel ? ifb.y         : ifa.y;
    wire [31:0] m_res_data  = sel ? ifb.res_data  : ifa.res_data;
    wire        m_res_valid = sel ? ifb.res_valid : ifa.res_valid;
    wire [7:0]  m_op_count  = sel ? ifb.op_count  : ifa.op_count;

    pds_operand_sequencer #(.LATENCY(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    pds_operand_sequencer #(.LATENCY(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    // Inputs change 1 time unit after a rising edge, so they are stable for the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one word until accepted; a Y accept pushes the expected result
    task automatic apply_stimulus(input logic [15:0] w, input bit is_y,
                                  input logic [31:0] exp_data, input int gap);
        bit  rdy;
        bit  done;
        time t;
        done = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 16'($urandom);
            step();
        end
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rdy = m_in_ready;
            @(posedge clk);
            t = $time;
            #1;
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            fail_now("word_accept_timeout");
        end else if (is_y) begin
            sb.push_back('{data: exp_data, x: last_x, y: w, yt: t});
        end else begin
            last_x = w;
        end
    endtask

    task automatic apply_pair(input logic [15:0] xw, input logic [15:0] yw,
                              input logic [31:0] exp_data, input int gap);
        apply_stimulus(xw, 1'b0, 32'd0, gap);
        apply_stimulus(yw, 1'b1, exp_data, gap);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sb.size() == 0 && !m_busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) fail_now("drain_timeout");
    endtask

    // Monitor: checks capture latency on RES_VALID rise and pops on each handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (m_res_valid && !prev_valid) begin
                if (sb.size() == 0) fail_now("unexpected_result");
                else check_output("capture_latency", 32'(($time - 5 - sb[0].yt) / 10),
                                  sel ? 32'd1 : 32'd4);
            end
            if (m_res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    fail_now("handshake_without_expectation");
                end else begin
                    e = sb.pop_front();
                    check_output("res_data", m_res_data, e.data);
                    check_output("x_hold", {16'd0, m_x}, {16'd0, e.x});
                    check_output("y_hold", {16'd0, m_y}, {16'd0, e.y});
                    check_output("op_count_pre", {24'd0, m_op_count},
                                 {24'd0, sel ? exp_ops_b : exp_ops_a});
                end
                if (sel) exp_ops_b = exp_ops_b + 8'd1;
                else     exp_ops_a = exp_ops_a + 8'd1;
            end
            prev_valid = m_res_valid;
        end
    end

    // Directed sequence
    initial begin
        logic [15:0] wx;
        logic [15:0] wy;

        repeat (3) step();
        check_output("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
        check_output("rst_busy", {31'd0, m_busy}, 32'd0);
        check_output("rst_res_valid", {31'd0, m_res_valid}, 32'd0);
        check_output("rst_op_count", {24'd0, m_op_count}, 32'd0);
        rst_n = 1'b1;
        step();
        res_ready = 1'b1;

        // Basic pair 5,3 -> 8*2
        apply_pair(16'd5, 16'd3, 32'h0000_0010, 0);
        check_output("t2_x", {16'd0, m_x}, 32'd5);
        check_output("t2_y", {16'd0, m_y}, 32'd3);
        check_output("t2_busy", {31'd0, m_busy}, 32'd1);
        wait_drain();
        check_output("t2_op_count", {24'd0, m_op_count}, 32'd1);

        // Negative difference wraps: 8*0xFFFE
        apply_pair(16'd3, 16'd5, 32'h0007_FFF0, 0);
        wait_drain();
        check_output("t3_op_count", {24'd0, m_op_count}, 32'd2);

        // Asynchronous reset in the middle of the settle phase
        apply_pair(16'd7, 16'd2, 32'h0000_002D, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t1_x", {16'd0, m_x}, 32'd0);
        check_output("t1_y", {16'd0, m_y}, 32'd0);
        check_output("t1_res_data", m_res_data, 32'd0);
        check_output("t1_res_valid", {31'd0, m_res_valid}, 32'd0);
        check_output("t1_op_count", {24'd0, m_op_count}, 32'd0);
        check_output("t1_in_ready", {31'd0, m_in_ready}, 32'd1);
        check_output("t1_busy", {31'd0, m_busy}, 32'd0);
        sb.delete();
        exp_ops_a = 8'd0;
        step();
        rst_n = 1'b1;
        step();
        apply_pair(16'd9, 16'd4, 32'h0000_0041, 0);
        wait_drain();
        check_output("t1_fresh_op_count", {24'd0, m_op_count}, 32'd1);

        // Result backpressure with ignored input pulses
        res_ready = 1'b0;
        apply_pair(16'd100, 16'd50, 32'h0000_1D4C, 0);
        for (int n = 0; n < 20 && !m_res_valid; n++) step();
        if (!m_res_valid) fail_now("t4_result_timeout");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 16'hDEAD;
            step();
            check_output("t4_res_valid", {31'd0, m_res_valid}, 32'd1);
            check_output("t4_res_data", m_res_data, 32'h0000_1D4C);
            check_output("t4_in_ready", {31'd0, m_in_ready}, 32'd0);
            check_output("t4_x", {16'd0, m_x}, 32'd100);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        check_output("t4_op_count", {24'd0, m_op_count}, 32'd2);
        check_output("t4_res_valid_low", {31'd0, m_res_valid}, 32'd0);
        check_output("t4_in_ready_back", {31'd0, m_in_ready}, 32'd1);
        step();
        check_output("t4_single_handshake", {24'd0, m_op_count}, 32'd2);

        // Gappy input over 20 pairs
        for (int i = 0; i < 20; i++) begin
            wx = 16'($urandom);
            wy = 16'($urandom);
            apply_stimulus(wx, 1'b0, 32'd0, int'($urandom_range(0, 3)));
            apply_stimulus(wy, 1'b1, model(wx, wy), int'($urandom_range(0, 3)));
        end
        wait_drain();
        check_output("t5_op_count", {24'd0, m_op_count}, 32'd22);

        // LATENCY=1 instance, 256 back-to-back operations wrap the count
        sel = 1'b1;
        step();
        for (int i = 0; i < 256; i++) begin
            wx = 16'(i * 131 + 1);
            wy = 16'(i * 7);
            apply_pair(wx, wy, model(wx, wy), 0);
        end
        wait_drain();
        check_output("t6_op_count_wrap", {24'd0, m_op_count}, 32'd0);
        check_output("t6_other_unchanged", {24'd0, ifa.op_count}, 32'd22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
